// File: rtl/cpu_run_controller.sv
// rtl/cpu_run_controller.sv - step/run/reset sequencer producing the MIPS core clock enable and reset.
// Optional PC breakpoint in free-run mode is built when CPU_BREAKPOINT_EN is defined.
module cpu_run_controller #(
  parameter int RUN_DIV    = 100_000,
  parameter int RST_CYCLES = 4,
  parameter int CNT_W      = 16
) (
  input  logic             basys_clk,
  input  logic             clr_n,
  input  logic             step_pulse,
  input  logic             run_toggle,
  input  logic             reset_pulse,
  input  logic [31:0]      pc,
  input  logic [31:0]      bp_addr,
  input  logic             bp_enable,
  output logic             cpu_ce,
  output logic             cpu_reset,
  output logic             running,
  output logic             halted,
  output logic [CNT_W-1:0] instr_count
);

  localparam int DIV_W = $clog2(RUN_DIV);
  localparam int RST_W = $clog2(RST_CYCLES + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RUN_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
  localparam logic [RST_W-1:0] RST_LAST = RST_W'(RST_CYCLES - 1);
  localparam logic [RST_W-1:0] RST_ONE  = RST_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [2:0] {S_RESET, S_IDLE, S_STEP, S_RUN, S_HALT} state_t;

  state_t           state;
  logic [DIV_W-1:0] div_cnt;
  logic [RST_W-1:0] rst_cnt;
  logic             halted_q;
  logic             skip_bp;
  logic             bp_hit;

`ifdef CPU_BREAKPOINT_EN
  // skip_bp lets the first issue after HALT step over the breakpointed instruction.
  assign bp_hit = bp_enable && (pc[31:2] == bp_addr[31:2]) && !skip_bp;
  assign halted = halted_q;
  logic unused_low_bits;
  assign unused_low_bits = ^{pc[1:0], bp_addr[1:0]};
`else
  assign bp_hit = 1'b0;
  assign halted = 1'b0;
  logic unused_bp;
  assign unused_bp = ^{pc, bp_addr, bp_enable, halted_q, skip_bp};
`endif

  always_ff @(posedge basys_clk) begin
    if (!clr_n || reset_pulse) begin
      state       <= S_RESET;
      rst_cnt     <= '0;
      div_cnt     <= '0;
      instr_count <= '0;
      cpu_reset   <= 1'b1;
      cpu_ce      <= 1'b0;
      running     <= 1'b0;
      halted_q    <= 1'b0;
      skip_bp     <= 1'b0;
    end else begin
      cpu_ce <= 1'b0;
      case (state)
        S_RESET: begin
          if (rst_cnt == RST_LAST) begin
            state     <= S_IDLE;
            cpu_reset <= 1'b0;
          end else begin
            rst_cnt <= rst_cnt + RST_ONE;
          end
        end
        S_IDLE, S_HALT: begin
          if (run_toggle) begin
            state    <= S_RUN;
            running  <= 1'b1;
            halted_q <= 1'b0;
            div_cnt  <= '0;
            skip_bp  <= (state == S_HALT);
          end else if (step_pulse) begin
            state       <= S_STEP;
            halted_q    <= 1'b0;
            cpu_ce      <= 1'b1;
            instr_count <= instr_count + CNT_ONE;
            skip_bp     <= 1'b0;
          end
        end
        S_STEP: state <= S_IDLE;
        S_RUN: begin
          if (run_toggle) begin
            state   <= S_IDLE;
            running <= 1'b0;
            div_cnt <= '0;
          end else if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            if (bp_hit) begin
              state    <= S_HALT;
              running  <= 1'b0;
              halted_q <= 1'b1;
            end else begin
              cpu_ce      <= 1'b1;
              instr_count <= instr_count + CNT_ONE;
              skip_bp     <= 1'b0;
            end
          end else begin
            div_cnt <= div_cnt + DIV_ONE;
          end
        end
        default: begin
          state     <= S_RESET;
          rst_cnt   <= '0;
          cpu_reset <= 1'b1;
          running   <= 1'b0;
          halted_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_run_controller.sv
// tb/tb_cpu_run_controller.sv - directed and random checks of cpu_run_controller against a cycle model.
module tb_cpu_run_controller;
  localparam int RUN_DIV = 4, RST_CYCLES = 4, CNT_W = 16;
`ifdef CPU_BREAKPOINT_EN
  localparam bit BP_ON = 1'b1;
`else
  localparam bit BP_ON = 1'b0;
`endif
  localparam int M_IDLE = 0, M_STEP = 1, M_RUN = 2, M_HALT = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic clr_n = 1'b0, step_pulse = 1'b0, run_toggle = 1'b0, reset_pulse = 1'b0, bp_enable = 1'b0;
  logic [31:0] pc = 32'h0, bp_addr = 32'h0;
  logic cpu_ce, cpu_reset, running, halted;
  logic [CNT_W-1:0] instr_count;

  int compared = 0, mismatched = 0;
  int ce_acc = 0, rst_acc = 0;

  cpu_run_controller #(.RUN_DIV(RUN_DIV), .RST_CYCLES(RST_CYCLES), .CNT_W(CNT_W)) dut (
    .basys_clk(clk), .clr_n(clr_n), .step_pulse(step_pulse), .run_toggle(run_toggle),
    .reset_pulse(reset_pulse), .pc(pc), .bp_addr(bp_addr), .bp_enable(bp_enable),
    .cpu_ce(cpu_ce), .cpu_reset(cpu_reset), .running(running), .halted(halted),
    .instr_count(instr_count)
  );

  // Core PC stand-in: advances one word per enabled cycle, cleared by core reset.
  always @(posedge clk) begin
    if (cpu_reset === 1'b1) pc <= 32'h0;
    else if (cpu_ce === 1'b1) pc <= pc + 32'd4;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    compared++;
    if (act !== want) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, want, $time);
    end
  endtask

  // Behavioural model: reset countdown, run age in cycles, pending breakpoint skip.
  int m_rst_left = 0, m_mode = M_IDLE, m_age = 0;
  bit m_skip = 0, m_ce = 0, m_valid = 0;
  logic [15:0] m_cnt = 16'h0;

  always @(posedge clk) begin
    if (!clr_n || reset_pulse) begin
      m_rst_left = RST_CYCLES; m_mode = M_IDLE; m_ce = 0; m_cnt = 16'h0; m_skip = 0; m_valid = 1;
    end else if (m_rst_left > 0) begin
      m_rst_left--; m_ce = 0; m_mode = M_IDLE;
    end else begin
      m_ce = 0;
      if (m_mode == M_IDLE || m_mode == M_HALT) begin
        if (run_toggle) begin
          m_skip = (m_mode == M_HALT); m_mode = M_RUN; m_age = 0;
        end else if (step_pulse) begin
          m_mode = M_STEP; m_ce = 1; m_cnt++; m_skip = 0;
        end
      end else if (m_mode == M_STEP) begin
        m_mode = M_IDLE;
      end else if (run_toggle) begin
        m_mode = M_IDLE;
      end else begin
        m_age++;
        if (m_age % RUN_DIV == 0) begin
          if (BP_ON && bp_enable && pc[31:2] == bp_addr[31:2] && !m_skip) m_mode = M_HALT;
          else begin m_ce = 1; m_cnt++; m_skip = 0; end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("cpu_ce", 32'(cpu_ce), 32'(m_ce));
      chk("cpu_reset", 32'(cpu_reset), 32'(m_rst_left > 0));
      chk("running", 32'(running), 32'(m_rst_left == 0 && m_mode == M_RUN));
      chk("halted", 32'(halted), 32'(m_rst_left == 0 && m_mode == M_HALT));
      chk("instr_count", 32'(instr_count), 32'(m_cnt));
      chk("ce_during_reset", 32'(cpu_ce & cpu_reset), 32'h0);
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      if (cpu_ce === 1'b1) ce_acc++;
      if (cpu_reset === 1'b1) rst_acc++;
    end
  endtask

  initial begin
    bit hit;
    // Reset: clr_n low for two edges, cpu_reset must stay high four cycles from release.
    tick(1);
    ce_acc = 0; rst_acc = 0;
    tick(1);
    clr_n = 1'b1;
    tick(9);
    chk("reset_len", 32'(rst_acc), 32'd4);
    chk("reset_no_ce", 32'(ce_acc), 32'd0);
    chk("reset_count", 32'(instr_count), 32'd0);

    // Step: three pulses, one-cycle latency each.
    ce_acc = 0;
    for (int i = 0; i < 3; i++) begin
      step_pulse = 1'b1; tick(1); step_pulse = 1'b0;
      chk("step_latency", 32'(cpu_ce), 32'd1);
      tick(4);
    end
    chk("step_pulses", 32'(ce_acc), 32'd3);
    chk("step_count", 32'(instr_count), 32'd3);

    // Run: first pulse four cycles after entry, five pulses over twenty cycles.
    ce_acc = 0;
    run_toggle = 1'b1; tick(1); run_toggle = 1'b0;
    chk("run_entry", 32'(running), 32'd1);
    tick(3);
    chk("run_first_early", 32'(cpu_ce), 32'd0);
    tick(1);
    chk("run_first", 32'(cpu_ce), 32'd1);
    tick(16);
    run_toggle = 1'b1; tick(1); run_toggle = 1'b0;
    chk("run_exit", 32'(running), 32'd0);
    tick(8);
    chk("run_pulses", 32'(ce_acc), 32'd5);
    chk("run_count", 32'(instr_count), 32'd8);

    // Priority: toggle beats step; reset_pulse aborts a run.
    run_toggle = 1'b1; step_pulse = 1'b1; tick(1); run_toggle = 1'b0; step_pulse = 1'b0;
    chk("prio_run", 32'(running), 32'd1);
    chk("prio_no_step", 32'(cpu_ce), 32'd0);
    tick(6);
    rst_acc = 0;
    reset_pulse = 1'b1; tick(1); reset_pulse = 1'b0;
    chk("rp_ce", 32'(cpu_ce), 32'd0);
    chk("rp_reset", 32'(cpu_reset), 32'd1);
    chk("rp_count", 32'(instr_count), 32'd0);
    ce_acc = 0;
    tick(8);
    chk("rp_len", 32'(rst_acc), 32'd4);
    chk("rp_no_ce", 32'(ce_acc), 32'd0);

`ifdef CPU_BREAKPOINT_EN
    // Breakpoint at 0x0C (low bits set to show they are ignored).
    bp_addr = 32'h0000_000E; bp_enable = 1'b1; ce_acc = 0;
    run_toggle = 1'b1; tick(1); run_toggle = 1'b0;
    hit = 0;
    for (int i = 0; i < 40 && !hit; i++) begin tick(1); hit = (halted === 1'b1); end
    chk("bp_halted", 32'(hit), 32'd1);
    chk("bp_pulses", 32'(ce_acc), 32'd3);
    chk("bp_pc", pc, 32'h0000_000C);
    chk("bp_not_running", 32'(running), 32'd0);
    run_toggle = 1'b1; tick(1); run_toggle = 1'b0;
    hit = 0;
    for (int i = 0; i < 20 && !hit; i++) begin tick(1); hit = (pc == 32'h10); end
    chk("bp_resume_pc", pc, 32'h0000_0010);
    tick(8);
    chk("bp_resume_run", 32'(running), 32'd1);
    chk("bp_resume_pc2", pc, 32'h0000_0018);
    run_toggle = 1'b1; tick(1); run_toggle = 1'b0;
    bp_enable = 1'b0;
    tick(2);
`endif

    // Wrap: preload counter to all ones, one step rolls it to zero.
    force dut.instr_count = 16'hFFFF;
    m_cnt = 16'hFFFF;
    tick(1);
    release dut.instr_count;
    chk("wrap_preload", 32'(instr_count), 32'h0000_FFFF);
    step_pulse = 1'b1; tick(1); step_pulse = 1'b0;
    chk("wrap_zero", 32'(instr_count), 32'h0);
    chk("wrap_ce", 32'(cpu_ce), 32'd1);
    tick(2);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      clr_n       = ($urandom_range(0, 199) != 0);
      reset_pulse = ($urandom_range(0, 79) == 0);
      run_toggle  = ($urandom_range(0, 11) == 0);
      step_pulse  = ($urandom_range(0, 7) == 0);
      bp_enable   = 1'($urandom_range(0, 1));
      bp_addr     = pc + 32'($urandom_range(0, 2)) * 32'd4 + 32'($urandom_range(0, 3));
      tick(1);
    end
    clr_n = 1'b1; reset_pulse = 1'b0; run_toggle = 1'b0; step_pulse = 1'b0;
    tick(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
